// File: rtl/fmap_pkg.sv
// Shared types and elaboration helpers for the feature-map write scheduler.
package fmap_pkg;

   typedef enum logic {FILL, WAIT_REL} fmap_wr_state_t;

   function automatic int unsigned total_pixels(input int unsigned width);
      return width * width;
   endfunction

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin arbiter granting up to ProcessingElements requesters per cycle,
// scanning upward from rr_ptr_i and assigning ports in scan order.
module rr_multi_grant
   import fmap_pkg::*;
#(
   parameter int unsigned NumberOfK          = 4,
   parameter int unsigned ProcessingElements = 2,
   parameter int unsigned KidxW              = 2
) (
   input  logic [NumberOfK-1:0]                        req_i,
   input  logic [KidxW-1:0]                            rr_ptr_i,
   output logic [ProcessingElements-1:0]               gnt_valid_o,
   output logic [ProcessingElements-1:0][KidxW-1:0]    gnt_idx_o,
   output logic [NumberOfK-1:0]                        gnt_mask_o,
   output logic [KidxW-1:0]                            rr_ptr_o
);

   localparam int unsigned PortW = idx_width(ProcessingElements);

   always_comb begin
      int unsigned port;
      int unsigned idx;
      gnt_valid_o = '0;
      gnt_idx_o   = '0;
      gnt_mask_o  = '0;
      rr_ptr_o    = rr_ptr_i;
      port        = 0;
      idx         = 0;
      for (int unsigned i = 0; i < NumberOfK; i++) begin
         idx = (32'(rr_ptr_i) + i) % NumberOfK;
         if (req_i[KidxW'(idx)] && (port < ProcessingElements)) begin
            gnt_valid_o[PortW'(port)] = 1'b1;
            gnt_idx_o[PortW'(port)]   = KidxW'(idx);
            gnt_mask_o[KidxW'(idx)]   = 1'b1;
            // Pointer moves just past the most recently granted kernel.
            rr_ptr_o                  = KidxW'((idx + 1) % NumberOfK);
            port                      = port + 1;
         end
      end
   end

endmodule

// File: rtl/fmap_write_scheduler.sv
// Buffers one pixel per kernel stream and issues round-robin BRAM writes, one frame at a time,
// stalling after each frame until the readout side releases the buffer.
module fmap_write_scheduler
   import fmap_pkg::*;
#(
   parameter int unsigned NumberOfK          = 4,
   parameter int unsigned BitSize            = 32,
   parameter int unsigned ProcessingElements = 2,
   parameter int unsigned ImageWidth         = 4,
   parameter int unsigned AddrWidth          = 32
) (
   input  logic                                           clk_i,
   input  logic                                           res_i,
   input  logic [NumberOfK-1:0]                           in_valid_i,
   input  logic [NumberOfK-1:0][BitSize-1:0]              in_data_i,
   output logic [NumberOfK-1:0]                           in_ready_o,
   output logic [ProcessingElements-1:0]                  wr_en_o,
   output logic [ProcessingElements-1:0][AddrWidth-1:0]   wr_addr_o,
   output logic [ProcessingElements-1:0][BitSize-1:0]     wr_data_o,
   output logic                                           frame_done_o,
   input  logic                                           buf_release_i
);

   localparam int unsigned TotalPixels = total_pixels(ImageWidth);
   localparam int unsigned KIDX_W      = idx_width(NumberOfK);
   localparam int unsigned CNT_W       = $clog2(TotalPixels + 1);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(TotalPixels);

   if ((ProcessingElements > NumberOfK) || (BitSize > 32) ||
       (longint'(NumberOfK) * longint'(TotalPixels) > (longint'(1) << AddrWidth)))
   begin : g_param_err
      $error("fmap_write_scheduler: illegal parameter combination");
   end

   fmap_wr_state_t state_q, state_d;

   logic [NumberOfK-1:0]                         hold_v_q, hold_v_d;
   logic [NumberOfK-1:0][BitSize-1:0]            hold_d_q, hold_d_d;
   logic [NumberOfK-1:0][CNT_W-1:0]              acc_cnt_q, acc_cnt_d;
   logic [NumberOfK-1:0][CNT_W-1:0]              wr_cnt_q, wr_cnt_d;
   logic [KIDX_W-1:0]                            rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
   logic [ProcessingElements-1:0]                wr_en_q, wr_en_d;
   logic [ProcessingElements-1:0][AddrWidth-1:0] wr_addr_q, wr_addr_d;
   logic [ProcessingElements-1:0][BitSize-1:0]   wr_data_q, wr_data_d;
   logic                                         frame_done_q, frame_done_d;

   logic [ProcessingElements-1:0]                gnt_valid;
   logic [ProcessingElements-1:0][KIDX_W-1:0]    gnt_idx;
   logic [NumberOfK-1:0]                         gnt_mask, req, accept;
   logic                                         fill, release_buf, frame_complete;

   assign req = hold_v_q & {NumberOfK{fill}};

   rr_multi_grant #(
      .NumberOfK          (NumberOfK),
      .ProcessingElements (ProcessingElements),
      .KidxW              (KIDX_W)
   ) u_rr_multi_grant (
      .req_i       (req),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx),
      .gnt_mask_o  (gnt_mask),
      .rr_ptr_o    (rr_ptr_nxt)
   );

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:     if (frame_complete) state_d = WAIT_REL;
         WAIT_REL: if (buf_release_i)  state_d = FILL;
      endcase
   end

   always_comb begin
      fill         = 1'b0;
      release_buf  = 1'b0;
      frame_done_d = 1'b0;
      unique case (state_q)
         FILL: begin
            fill         = 1'b1;
            frame_done_d = frame_complete;
         end
         WAIT_REL: release_buf = buf_release_i;
      endcase
   end

   // A held pixel may be replaced in the same cycle it is granted.
   always_comb begin
      for (int k = 0; k < NumberOfK; k++) begin
         in_ready_o[k] = fill && !res_i && (acc_cnt_q[k] < CntMax) &&
                         (!hold_v_q[k] || gnt_mask[k]);
      end
   end

   assign accept = in_ready_o & in_valid_i;

   always_comb begin
      hold_v_d       = hold_v_q;
      hold_d_d       = hold_d_q;
      acc_cnt_d      = acc_cnt_q;
      wr_cnt_d       = wr_cnt_q;
      frame_complete = 1'b1;
      for (int k = 0; k < NumberOfK; k++) begin
         if (gnt_mask[k]) begin
            hold_v_d[k] = 1'b0;
            wr_cnt_d[k] = wr_cnt_q[k] + CNT_W'(1);
         end
         if (accept[k]) begin
            hold_v_d[k]  = 1'b1;
            hold_d_d[k]  = in_data_i[k];
            acc_cnt_d[k] = acc_cnt_q[k] + CNT_W'(1);
         end
         if (wr_cnt_d[k] != CntMax) frame_complete = 1'b0;
      end
      if (release_buf) begin
         acc_cnt_d = '0;
         wr_cnt_d  = '0;
      end
      rr_ptr_d = release_buf ? '0 : rr_ptr_nxt;
   end

   always_comb begin
      wr_en_d   = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      for (int j = 0; j < ProcessingElements; j++) begin
         if (gnt_valid[j]) begin
            wr_en_d[j]   = 1'b1;
            wr_addr_d[j] = AddrWidth'(gnt_idx[j]) * AddrWidth'(TotalPixels) +
                           AddrWidth'(wr_cnt_q[gnt_idx[j]]);
            wr_data_d[j] = hold_d_q[gnt_idx[j]];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         hold_v_q     <= '0;
         hold_d_q     <= '0;
         acc_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         rr_ptr_q     <= '0;
         wr_en_q      <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         hold_v_q     <= hold_v_d;
         hold_d_q     <= hold_d_d;
         acc_cnt_q    <= acc_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fmap_write_scheduler.sv
// Randomized bench for fmap_write_scheduler against a queue-based frame/arbitration model.
module tb_fmap_write_scheduler;

   localparam int K  = 4;
   localparam int P  = 2;
   localparam int TP = 16;
   localparam int B  = 32;
   localparam int AW = 32;

   logic                    clk = 1'b0;
   logic                    res;
   logic [K-1:0]            in_valid;
   logic [K-1:0][B-1:0]     in_data;
   logic [K-1:0]            in_ready;
   logic [P-1:0]            wr_en;
   logic [P-1:0][AW-1:0]    wr_addr;
   logic [P-1:0][B-1:0]     wr_data;
   logic                    frame_done;
   logic                    buf_release;

   always #5 clk = ~clk;

   fmap_write_scheduler #(
      .NumberOfK          (K),
      .BitSize            (B),
      .ProcessingElements (P),
      .ImageWidth         (4),
      .AddrWidth          (AW)
   ) dut (
      .clk_i         (clk),
      .res_i         (res),
      .in_valid_i    (in_valid),
      .in_data_i     (in_data),
      .in_ready_o    (in_ready),
      .wr_en_o       (wr_en),
      .wr_addr_o     (wr_addr),
      .wr_data_o     (wr_data),
      .frame_done_o  (frame_done),
      .buf_release_i (buf_release)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus: pending pixel per kernel, held until accepted.
   logic [K-1:0]  pend;
   logic [31:0]   pdata[K];
   logic [K-1:0]  rdy_s;

   // Reference model.
   bit            m_fill;
   bit            m_hold[K];
   logic [31:0]   m_q[K][$];
   int            m_acc[K];
   int            m_wr[K];
   int            m_ptr;
   logic [P-1:0]  m_en;
   logic [31:0]   m_addr[P];
   logic [31:0]   m_data[P];
   bit            m_done;

   // Observations.
   int            wcount;
   int            done_cnt;
   int            seen[64];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_fill = 1'b1;
      m_ptr  = 0;
      m_en   = '0;
      m_done = 1'b0;
      for (int k = 0; k < K; k++) begin
         m_hold[k] = 1'b0;
         m_q[k].delete();
         m_acc[k] = 0;
         m_wr[k]  = 0;
      end
      for (int j = 0; j < P; j++) begin
         m_addr[j] = '0;
         m_data[j] = '0;
      end
   endfunction

   task automatic gen(input int pct);
      for (int k = 0; k < K; k++) begin
         if (!pend[k] && ($urandom_range(0, 99) < pct)) begin
            pend[k]  = 1'b1;
            pdata[k] = $urandom;
         end
      end
   endtask

   // One clock cycle: drive at negedge, predict, compare ready, clock, compare outputs.
   task automatic step(input bit rst, input bit rel);
      int           gk[P];
      int           gn;
      int           last;
      bit           all_done;
      logic [K-1:0] gmask;
      logic [K-1:0] m_rdy;
      logic [K-1:0] acc;
      res         = rst;
      buf_release = rel;
      for (int k = 0; k < K; k++) begin
         in_valid[k] = pend[k];
         in_data[k]  = pdata[k];
      end
      gn    = 0;
      last  = -1;
      gmask = '0;
      for (int i = 0; i < K; i++) begin
         int idx;
         idx = (m_ptr + i) % K;
         if (m_fill && m_hold[idx] && gn < P) begin
            gk[gn] = idx;
            gn++;
            gmask[idx] = 1'b1;
            last = idx;
         end
      end
      for (int k = 0; k < K; k++) begin
         m_rdy[k] = !rst && m_fill && (m_acc[k] < TP) && (!m_hold[k] || gmask[k]);
      end
      #1;
      check("in_ready", in_ready, m_rdy);
      rdy_s = in_ready;
      acc   = m_rdy & pend;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         m_en = '0;
         for (int n = 0; n < gn; n++) begin
            m_en[n]   = 1'b1;
            m_addr[n] = gk[n] * TP + m_wr[gk[n]];
            m_data[n] = m_q[gk[n]].pop_front();
            m_wr[gk[n]]++;
            m_hold[gk[n]] = 1'b0;
         end
         for (int k = 0; k < K; k++) begin
            if (acc[k]) begin
               m_q[k].push_back(pdata[k]);
               m_hold[k] = 1'b1;
               m_acc[k]++;
            end
         end
         if (last >= 0) m_ptr = (last + 1) % K;
         m_done = 1'b0;
         if (m_fill) begin
            all_done = 1'b1;
            for (int k = 0; k < K; k++) if (m_wr[k] != TP) all_done = 1'b0;
            if (all_done) begin
               m_fill = 1'b0;
               m_done = 1'b1;
            end
         end else if (rel) begin
            for (int k = 0; k < K; k++) begin
               m_acc[k] = 0;
               m_wr[k]  = 0;
            end
            m_ptr  = 0;
            m_fill = 1'b1;
         end
      end
      #1;
      check("wr_en", wr_en, m_en);
      check("frame_done", frame_done, m_done);
      for (int j = 0; j < P; j++) begin
         check($sformatf("wr_addr%0d", j), wr_addr[j], m_addr[j]);
         check($sformatf("wr_data%0d", j), wr_data[j], m_data[j]);
         if (wr_en[j]) begin
            wcount++;
            if (wr_addr[j] < 64) seen[wr_addr[j]]++;
         end
      end
      if (frame_done) done_cnt++;
      pend = pend & ~acc;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int guard;
      logic [31:0] x;
      res         = 1'b1;
      buf_release = 1'b0;
      in_valid    = '0;
      in_data     = '0;
      pend        = '0;
      for (int k = 0; k < K; k++) pdata[k] = '0;
      model_reset();
      wcount   = 0;
      done_cnt = 0;
      @(negedge clk);

      // Reset state.
      step(1, 0);
      step(1, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_addr0", wr_addr[0], 0);

      // Single kernel, two-cycle latency.
      pend[0] = 1'b1; pdata[0] = 32'hA5;
      step(0, 0);
      step(0, 0);
      check("t1_en", wr_en, 2'b01);
      check("t1_addr", wr_addr[0], 0);
      check("t1_data", wr_data[0], 32'hA5);

      // All kernels at once from pointer 0.
      step(1, 0);
      pend = '1;
      for (int k = 0; k < K; k++) pdata[k] = k;
      step(0, 0);
      gen(100);
      step(0, 0);
      check("t2_ready_hi", rdy_s[3:2], 2'b00);
      check("t2_ready_lo", rdy_s[1:0], 2'b11);
      check("t2a_en", wr_en, 2'b11);
      check("t2a_addr0", wr_addr[0], 0);
      check("t2a_addr1", wr_addr[1], 16);
      check("t2a_data1", wr_data[1], 1);
      step(0, 0);
      check("t2b_addr0", wr_addr[0], 32);
      check("t2b_addr1", wr_addr[1], 48);
      check("t2b_data0", wr_data[0], 2);
      check("t2b_data1", wr_data[1], 3);

      // Full random frame; releases in FILL must be ignored.
      step(1, 0);
      pend     = '0;
      wcount   = 0;
      done_cnt = 0;
      for (int a = 0; a < 64; a++) seen[a] = 0;
      guard = 0;
      while (done_cnt == 0 && guard < 600) begin
         gen(70);
         step(0, m_fill && ($urandom_range(0, 9) == 0));
         guard++;
      end
      check("t3_done_seen", done_cnt, 1);
      check("t3_writes", wcount, 64);
      for (int a = 0; a < 64; a++) check($sformatf("t3_addr_once%0d", a), seen[a], 1);

      // Held off in WAIT_REL, then released.
      base = wcount;
      for (int c = 0; c < 10; c++) begin
         gen(100);
         step(0, 0);
      end
      check("t4_no_writes", wcount - base, 0);
      check("t4_ready_low", rdy_s, 4'h0);
      check("t4_single_done", done_cnt, 1);
      step(0, 1);
      step(0, 0);
      step(0, 0);
      check("t4_en", wr_en, 2'b11);
      check("t4_addr0", wr_addr[0], 0);
      check("t4_addr1", wr_addr[1], 16);

      // Release coincident with frame_done.
      done_cnt = 0;
      guard    = 0;
      while (done_cnt == 0 && guard < 300) begin
         gen(100);
         step(0, 0);
         guard++;
      end
      check("t6_done_seen", done_cnt, 1);
      gen(100);
      step(0, 1);
      gen(100);
      step(0, 0);
      check("t6_ready_all", rdy_s, 4'hF);

      // Reset in the middle of a frame.
      step(1, 0);
      pend  = '0;
      guard = 0;
      while (m_acc[1] < 5 && guard < 50) begin
         if (!pend[1]) begin
            pend[1]  = 1'b1;
            pdata[1] = $urandom;
         end
         step(0, 0);
         guard++;
      end
      check("t5_accepted", m_acc[1], 5);
      pend = '0;
      step(1, 0);
      check("t5_rst_en", wr_en, 0);
      check("t5_rst_addr1", wr_addr[1], 0);
      check("t5_rst_data0", wr_data[0], 0);
      x = $urandom;
      pend[1] = 1'b1; pdata[1] = x;
      step(0, 0);
      step(0, 0);
      check("t5_en", wr_en, 2'b01);
      check("t5_addr", wr_addr[0], 16);
      check("t5_data", wr_data[0], x);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
